eql_irq_ctrl: RTL and testbench

Parametrised multi-channel successor to the single-channel eql/cont_eql interrupt handshake controller. It replicates the per-channel handshake FSM NUM_CH times. A round-robin arbiter grants channels a shared cc_mux output bus. Each channel gains an acknowledge-timeout counter. It sits between the equality-comparator front end and the downstream counter/mux datapath.

---
 rtl/eql_ctrl_pkg.sv | 20 ++
 rtl/eql_ch_fsm.sv | 90 +++++++++
 rtl/eql_irq_ctrl.sv | 90 +++++++++
 tb/tb_eql_irq_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/eql_ctrl_pkg.sv
// Shared types for the multi-channel eql/cont_eql interrupt handshake controller.
// Holds the channel state encoding and the width helper for the granted-channel index.
package eql_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_ENIN   = 3'd2,
        ST_ENIN_W = 3'd3,
        ST_INTR   = 3'd4,
        ST_INTR_1 = 3'd5,
        ST_INTR_W = 3'd6
    } ch_state_t;

    // A single channel still needs a one-bit index so the bus port never collapses to zero width.
    function automatic int ch_idx_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/eql_ch_fsm.sv
// One handshake channel: Moore FSM, ENIN_W dwell timer and registered output decode.
// Requests the shared bus while in INTR and advances when the top grants it.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// INIT      | first cycle after reset, leaves unconditionally
// WAIT      | idle, waiting for eql
// ENIN      | counter enabled on first eql cycle
// ENIN_W    | counter enabled and acked while eql holds; dwell is timed
// INTR      | interrupt pending, requesting the shared cc_mux bus
// INTR_1    | bus granted this cycle; cont_eql decides hold or release
// INTR_W    | acked, holding until both eql and cont_eql drop
module eql_ch_fsm
    import eql_ctrl_pkg::*;
#(
    parameter int TO_W    = 8,
    parameter int TIMEOUT = 200
) (
    input  logic clock,
    input  logic reset_n,
    input  logic eql,
    input  logic cont_eql,
    input  logic grant,
    output logic req,
    output logic ackout,
    output logic enable_count,
    output logic timeout_err
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    ch_state_t       state;
    ch_state_t       state_nxt;
    logic [TO_W-1:0] to_cnt;
    logic [TO_W-1:0] to_cnt_nxt;
    logic            to_hit;
    logic            to_fire;

    assign to_hit = (TIMEOUT != 0) && (to_cnt == TO_LAST);
    assign req    = (state == ST_INTR);

    always_comb begin
        state_nxt = state;
        to_fire   = 1'b0;
        case (state)
            ST_INIT:   state_nxt = ST_WAIT;
            ST_WAIT:   if (eql) state_nxt = ST_ENIN;
            ST_ENIN:   state_nxt = eql ? ST_ENIN_W : ST_INTR;
            ST_ENIN_W: begin
                if (!eql) begin
                    state_nxt = ST_INTR;
                end else if (to_hit) begin
                    state_nxt = ST_INTR_W;
                    to_fire   = 1'b1;
                end
            end
            ST_INTR:   if (grant) state_nxt = ST_INTR_1;
            ST_INTR_1: state_nxt = cont_eql ? ST_INTR_W : ST_WAIT;
            ST_INTR_W: if (!eql && !cont_eql) state_nxt = ST_WAIT;
            default:   state_nxt = ST_INIT;
        endcase
    end

    // Saturating dwell counter, restarted on every entry to ENIN_W.
    always_comb begin
        to_cnt_nxt = to_cnt;
        if (state == ST_ENIN && state_nxt == ST_ENIN_W) begin
            to_cnt_nxt = '0;
        end else if (state == ST_ENIN_W && to_cnt != '1) begin
            to_cnt_nxt = to_cnt + TO_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_INIT;
            to_cnt       <= '0;
            enable_count <= 1'b0;
            ackout       <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            state        <= state_nxt;
            to_cnt       <= to_cnt_nxt;
            enable_count <= (state_nxt == ST_ENIN) || (state_nxt == ST_ENIN_W);
            ackout       <= (state_nxt == ST_ENIN_W) || (state_nxt == ST_INTR_W);
            timeout_err  <= to_fire;
        end
    end

endmodule

// File: rtl/eql_irq_ctrl.sv
// Multi-channel eql interrupt controller: NUM_CH handshake channels sharing one
// cc_mux bus through a round-robin arbiter.
module eql_irq_ctrl
    import eql_ctrl_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int CODE_W  = 2,
    parameter int TO_W    = 8,
    parameter int TIMEOUT = 200
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic [NUM_CH-1:0]           eql,
    input  logic [NUM_CH-1:0]           cont_eql,
    input  logic [NUM_CH*CODE_W-1:0]    ch_code,
    output logic [NUM_CH-1:0]           ackout,
    output logic [NUM_CH-1:0]           enable_count,
    output logic [NUM_CH-1:0]           timeout_err,
    output logic                        cc_mux_valid,
    output logic [ch_idx_w(NUM_CH)-1:0] cc_mux_ch,
    output logic [CODE_W-1:0]           cc_mux_code
);

    localparam int IDX_W = ch_idx_w(NUM_CH);

    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] grant;
    logic              grant_any;
    logic [IDX_W-1:0]  grant_idx;
    logic [CODE_W-1:0] grant_code;
    logic [IDX_W-1:0]  rr_ptr;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        eql_ch_fsm #(
            .TO_W    (TO_W),
            .TIMEOUT (TIMEOUT)
        ) u_ch (
            .clock        (clock),
            .reset_n      (reset_n),
            .eql          (eql[i]),
            .cont_eql     (cont_eql[i]),
            .grant        (grant[i]),
            .req          (req[i]),
            .ackout       (ackout[i]),
            .enable_count (enable_count[i]),
            .timeout_err  (timeout_err[i])
        );
    end

    // Two passes: first requester at or above rr_ptr, else wrap to the lowest requester.
    always_comb begin
        grant      = '0;
        grant_any  = 1'b0;
        grant_idx  = '0;
        grant_code = '0;
        for (int j = 0; j < NUM_CH; j++) begin
            if (!grant_any && req[j] && (j >= int'(rr_ptr))) begin
                grant_any  = 1'b1;
                grant[j]   = 1'b1;
                grant_idx  = IDX_W'(j);
                grant_code = ch_code[j*CODE_W +: CODE_W];
            end
        end
        for (int j = 0; j < NUM_CH; j++) begin
            if (!grant_any && req[j]) begin
                grant_any  = 1'b1;
                grant[j]   = 1'b1;
                grant_idx  = IDX_W'(j);
                grant_code = ch_code[j*CODE_W +: CODE_W];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr       <= '0;
            cc_mux_valid <= 1'b0;
            cc_mux_ch    <= '0;
            cc_mux_code  <= '0;
        end else begin
            cc_mux_valid <= grant_any;
            if (grant_any) begin
                rr_ptr      <= (grant_idx == IDX_W'(NUM_CH - 1)) ? '0 : grant_idx + IDX_W'(1);
                cc_mux_ch   <= grant_idx;
                cc_mux_code <= grant_code;
            end
        end
    end

endmodule

// File: tb/tb_eql_irq_ctrl.sv
// Directed bench for eql_irq_ctrl: vector table for handshake/arbitration/timeout on a
// 4-channel instance, plus hand sequences for mid-grant reset, TIMEOUT=0 and NUM_CH=1.
module tb_eql_irq_ctrl;
    import eql_ctrl_pkg::*;

    typedef struct packed {
        logic [3:0] eql;
        logic [3:0] cont;
        logic [3:0] ack;
        logic [3:0] en;
        logic [3:0] terr;
        logic       vld;
        logic [1:0] ch;
        logic [1:0] code;
    } vec_t;

    logic clock = 1'b0;
    logic reset_n = 1'b1;

    logic [3:0] eql_a = '0, cont_a = '0;
    logic [7:0] code_a = {2'd0, 2'd3, 2'd2, 2'd1};
    logic [3:0] ack_a, en_a, terr_a;
    logic       vld_a;
    logic [1:0] ch_a, mcode_a;

    logic [3:0] eql_z = '0, cont_z = '0;
    logic [7:0] code_z = 8'h1B;
    logic [3:0] ack_z, en_z, terr_z;
    logic       vld_z;
    logic [1:0] ch_z, mcode_z;

    logic       eql_s = 1'b0, cont_s = 1'b0;
    logic [3:0] code_s = '0;
    logic       ack_s, en_s, terr_s, vld_s;
    logic [0:0] ch_s;
    logic [3:0] mcode_s;

    int   n_chk = 0;
    int   n_fail = 0;
    vec_t tbl[$];

    always #5 clock = ~clock;

    eql_irq_ctrl #(.NUM_CH(4), .CODE_W(2), .TO_W(8), .TIMEOUT(5)) dut_a (
        .clock(clock), .reset_n(reset_n), .eql(eql_a), .cont_eql(cont_a), .ch_code(code_a),
        .ackout(ack_a), .enable_count(en_a), .timeout_err(terr_a),
        .cc_mux_valid(vld_a), .cc_mux_ch(ch_a), .cc_mux_code(mcode_a));

    eql_irq_ctrl #(.NUM_CH(4), .CODE_W(2), .TO_W(8), .TIMEOUT(0)) dut_z (
        .clock(clock), .reset_n(reset_n), .eql(eql_z), .cont_eql(cont_z), .ch_code(code_z),
        .ackout(ack_z), .enable_count(en_z), .timeout_err(terr_z),
        .cc_mux_valid(vld_z), .cc_mux_ch(ch_z), .cc_mux_code(mcode_z));

    eql_irq_ctrl #(.NUM_CH(1), .CODE_W(4), .TO_W(4), .TIMEOUT(3)) dut_s (
        .clock(clock), .reset_n(reset_n), .eql(eql_s), .cont_eql(cont_s), .ch_code(code_s),
        .ackout(ack_s), .enable_count(en_s), .timeout_err(terr_s),
        .cc_mux_valid(vld_s), .cc_mux_ch(ch_s), .cc_mux_code(mcode_s));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_a(input string tag, input vec_t v);
        chk({tag, " ackout"},       32'(ack_a),   32'(v.ack));
        chk({tag, " enable_count"}, 32'(en_a),    32'(v.en));
        chk({tag, " timeout_err"},  32'(terr_a),  32'(v.terr));
        chk({tag, " cc_mux_valid"}, 32'(vld_a),   32'(v.vld));
        chk({tag, " cc_mux_ch"},    32'(ch_a),    32'(v.ch));
        chk({tag, " cc_mux_code"},  32'(mcode_a), 32'(v.code));
    endtask

    task automatic add(input logic [3:0] e, input logic [3:0] c, input logic [3:0] a,
                       input logic [3:0] n, input logic [3:0] t, input logic vl,
                       input logic [1:0] ch, input logic [1:0] cd);
        vec_t v;
        v = '{eql: e, cont: c, ack: a, en: n, terr: t, vld: vl, ch: ch, code: cd};
        tbl.push_back(v);
    endtask

    initial begin
        logic [3:0] codes [3];
        int         pulses;
        codes[0] = 4'hA;
        codes[1] = 4'h5;
        codes[2] = 4'hF;

        // channel 0 single handshake
        add(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 2'd0);
        add(4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 1'b0, 2'd0, 2'd0);
        add(4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 1'b0, 2'd0, 2'd0);
        add(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 2'd0);
        add(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 2'd0, 2'd1);
        add(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 2'd1);
        // channels 1..3 contend
        add(4'b1110, 4'b0000, 4'b0000, 4'b1110, 4'b0000, 1'b0, 2'd0, 2'd1);
        add(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 2'd1);
        add(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 2'd1, 2'd2);
        add(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 2'd2, 2'd3);
        add(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 2'd3, 2'd0);
        add(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd3, 2'd0);
        // channel 2 alone moves rr_ptr to 3
        add(4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 1'b0, 2'd3, 2'd0);
        add(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd3, 2'd0);
        add(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 2'd2, 2'd3);
        add(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd2, 2'd3);
        // channels 0 and 3 with rr_ptr=3: 3 first, then wrap to 0
        add(4'b1001, 4'b0000, 4'b0000, 4'b1001, 4'b0000, 1'b0, 2'd2, 2'd3);
        add(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd2, 2'd3);
        add(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 2'd3, 2'd0);
        add(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 2'd0, 2'd1);
        add(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 2'd1);
        // channel 1 into INTR_W via cont_eql, held 3 cycles with eql=0
        add(4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 1'b0, 2'd0, 2'd1);
        add(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 2'd1);
        add(4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 1'b1, 2'd1, 2'd2);
        add(4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 1'b0, 2'd1, 2'd2);
        for (int i = 0; i < 3; i++)
            add(4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 1'b0, 2'd1, 2'd2);
        add(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd1, 2'd2);
        // channel 2 timeout with TIMEOUT=5
        add(4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 1'b0, 2'd1, 2'd2);
        for (int i = 0; i < 5; i++)
            add(4'b0100, 4'b0000, 4'b0100, 4'b0100, 4'b0000, 1'b0, 2'd1, 2'd2);
        add(4'b0100, 4'b0000, 4'b0100, 4'b0000, 4'b0100, 1'b0, 2'd1, 2'd2);
        add(4'b0100, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 1'b0, 2'd1, 2'd2);
        add(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd1, 2'd2);

        #2 reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset ackout",       32'(ack_a),   32'd0);
        chk("reset enable_count", 32'(en_a),    32'd0);
        chk("reset timeout_err",  32'(terr_a),  32'd0);
        chk("reset cc_mux_valid", 32'(vld_a),   32'd0);
        chk("reset cc_mux_ch",    32'(ch_a),    32'd0);
        chk("reset cc_mux_code",  32'(mcode_a), 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            eql_a  = tbl[i].eql;
            cont_a = tbl[i].cont;
            tick();
            chk_a($sformatf("vec%0d", i), tbl[i]);
        end

        // mid-grant reset: ch0 in INTR (grant pending), ch3 in ENIN_W
        eql_a = 4'b1001; cont_a = '0; tick();
        eql_a = 4'b1000; tick();
        chk("pre-reset enable_count", 32'(en_a),  32'h8);
        chk("pre-reset ackout",       32'(ack_a), 32'h8);
        eql_a   = '0;
        reset_n = 1'b0;
        #2;
        chk("async reset ackout",       32'(ack_a),   32'd0);
        chk("async reset enable_count", 32'(en_a),    32'd0);
        chk("async reset cc_mux_valid", 32'(vld_a),   32'd0);
        chk("async reset cc_mux_ch",    32'(ch_a),    32'd0);
        chk("async reset cc_mux_code",  32'(mcode_a), 32'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk($sformatf("in-reset cc_mux_valid %0d", i), 32'(vld_a), 32'd0);
        end
        reset_n = 1'b1;
        tick();
        chk("post-reset enable_count", 32'(en_a),  32'd0);
        chk("post-reset cc_mux_valid", 32'(vld_a), 32'd0);
        // rr_ptr back at 0: channels 1 and 3 together grant 1 first
        eql_a = 4'b1010; tick();
        chk("post-reset enin", 32'(en_a), 32'hA);
        eql_a = 4'b0000; tick();
        tick();
        chk("post-reset grant1 valid", 32'(vld_a),   32'd1);
        chk("post-reset grant1 ch",    32'(ch_a),    32'd1);
        chk("post-reset grant1 code",  32'(mcode_a), 32'd2);
        tick();
        chk("post-reset grant2 valid", 32'(vld_a),   32'd1);
        chk("post-reset grant2 ch",    32'(ch_a),    32'd3);
        chk("post-reset grant2 code",  32'(mcode_a), 32'd0);
        tick();
        chk("post-reset idle valid",   32'(vld_a),   32'd0);

        // TIMEOUT=0: eql held in ENIN_W never fires
        pulses = 0;
        eql_z  = 4'b0100;
        for (int i = 0; i < 310; i++) begin
            tick();
            if (terr_z != '0) pulses++;
        end
        chk("no-timeout pulses",       32'(pulses), 32'd0);
        chk("no-timeout ackout",       32'(ack_z),  32'h4);
        chk("no-timeout enable_count", 32'(en_z),   32'h4);
        eql_z = '0;

        // NUM_CH=1, CODE_W=4: back-to-back handshakes, code sampled only at grant
        for (int i = 0; i < 3; i++) begin
            eql_s  = 1'b1;
            code_s = ~codes[i];
            tick();
            chk($sformatf("single%0d enin", i), 32'(en_s), 32'd1);
            eql_s = 1'b0;
            tick();
            code_s = codes[i];
            tick();
            chk($sformatf("single%0d valid", i), 32'(vld_s),   32'd1);
            chk($sformatf("single%0d ch", i),    32'(ch_s),    32'd0);
            chk($sformatf("single%0d code", i),  32'(mcode_s), 32'(codes[i]));
            code_s = ~codes[i];
            tick();
            chk($sformatf("single%0d idle valid", i), 32'(vld_s),   32'd0);
            chk($sformatf("single%0d hold code", i),  32'(mcode_s), 32'(codes[i]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
